tage_tagged_bank: RTL and testbench

TAGE_TAGGED_BANK -- requirements
Module: tage_tagged_bank

---
 rtl/tage_tagged_bank.sv | 166 ++++++++++++++++
 tb/tb_tage_tagged_bank.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tage_tagged_bank.sv
// Single tagged bank of a TAGE predictor: 1-cycle registered lookup,
// train/allocate update port, and a background sweep engine that clears the
// table at start-up (INIT) and clears useful-bit planes on request (SWEEP).
module tage_tagged_bank #(
    parameter int INDEX_W = 10,
    parameter int TAG_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pause,
    input  logic [INDEX_W-1:0] pred_index,
    input  logic [TAG_W-1:0]   pred_tag,
    output logic               pred_hit,
    output logic [2:0]         pred_ctr,
    output logic [1:0]         pred_u,
    input  logic               upd_valid,
    input  logic [INDEX_W-1:0] upd_index,
    input  logic [TAG_W-1:0]   upd_tag,
    input  logic               upd_alloc,
    input  logic               upd_taken,
    input  logic               upd_u_inc,
    input  logic               upd_u_dec,
    input  logic               flush_ubits_hi,
    input  logic               flush_ubits_lo,
    output logic               flush_busy
);
    localparam int N = 1 << INDEX_W;

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_SWEEP} state_t;

    state_t             state_q;
    logic [INDEX_W-1:0] ptr_q;
    logic [1:0]         cmask_q;
    logic [1:0]         pmask_q;

    logic               valid_mem [N];
    logic [TAG_W-1:0]   tag_mem   [N];
    logic [2:0]         ctr_mem   [N];
    logic [1:0]         u_mem     [N];

    logic               pred_hit_q;
    logic [2:0]         pred_ctr_q;
    logic [1:0]         pred_u_q;

    logic [1:0]         flush_req;
    logic               last_ptr;
    logic [2:0]         cur_ctr;
    logic [1:0]         cur_u;
    logic [2:0]         upd_ctr_d;
    logic [1:0]         upd_u_d;
    logic [1:0]         swept_u_d;

    assign flush_req = {flush_ubits_hi, flush_ubits_lo};
    assign last_ptr  = &ptr_q;
    assign cur_ctr   = ctr_mem[upd_index];
    assign cur_u     = u_mem[upd_index];

    // New counter / useful value for the entry addressed by the update port
    always_comb begin
        upd_ctr_d = cur_ctr;
        upd_u_d   = cur_u;
        if (upd_alloc) begin
            upd_ctr_d = upd_taken ? 3'd4 : 3'd3;
            upd_u_d   = 2'd0;
        end else begin
            if (upd_taken && cur_ctr != 3'd7)
                upd_ctr_d = cur_ctr + 3'd1;
            else if (!upd_taken && cur_ctr != 3'd0)
                upd_ctr_d = cur_ctr - 3'd1;
            if (upd_u_inc && !upd_u_dec && cur_u != 2'd3)
                upd_u_d = cur_u + 2'd1;
            else if (upd_u_dec && !upd_u_inc && cur_u != 2'd0)
                upd_u_d = cur_u - 2'd1;
        end
    end

    // Swept entry: fold in a same-cycle update first so the clear always wins
    always_comb begin
        if (upd_valid && upd_index == ptr_q)
            swept_u_d = upd_u_d & ~cmask_q;
        else
            swept_u_d = u_mem[ptr_q] & ~cmask_q;
    end

    // Sweep engine: init pass, then idle, then u-clear passes (chained via pmask)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_INIT;
            ptr_q   <= '0;
            cmask_q <= 2'b00;
            pmask_q <= 2'b00;
        end else begin
            case (state_q)
                S_INIT: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (last_ptr)
                        state_q <= S_IDLE;
                end
                S_IDLE: begin
                    if ((flush_req | pmask_q) != 2'b00) begin
                        state_q <= S_SWEEP;
                        cmask_q <= flush_req | pmask_q;
                        pmask_q <= 2'b00;
                        ptr_q   <= '0;
                    end
                end
                S_SWEEP: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (last_ptr) begin
                        // A request on the final cycle is parked in pmask and
                        // picked up by IDLE (or the next pass) rather than lost.
                        if (pmask_q != 2'b00)
                            cmask_q <= pmask_q;
                        else
                            state_q <= S_IDLE;
                        pmask_q <= flush_req;
                    end else begin
                        pmask_q <= pmask_q | flush_req;
                    end
                end
                default: state_q <= S_INIT;
            endcase
        end
    end

    // Table storage: init clears, otherwise update then sweep clear
    always_ff @(posedge clk) begin
        if (state_q == S_INIT) begin
            valid_mem[ptr_q] <= 1'b0;
            tag_mem[ptr_q]   <= '0;
            ctr_mem[ptr_q]   <= 3'd0;
            u_mem[ptr_q]     <= 2'd0;
        end else begin
            if (upd_valid) begin
                if (upd_alloc) begin
                    valid_mem[upd_index] <= 1'b1;
                    tag_mem[upd_index]   <= upd_tag;
                end
                ctr_mem[upd_index] <= upd_ctr_d;
                u_mem[upd_index]   <= upd_u_d;
            end
            if (state_q == S_SWEEP)
                u_mem[ptr_q] <= swept_u_d;
        end
    end

    // Registered lookup; reads pre-update storage, held while paused
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_hit_q <= 1'b0;
            pred_ctr_q <= 3'd0;
            pred_u_q   <= 2'd0;
        end else if (!pause) begin
            pred_hit_q <= (state_q != S_INIT) && valid_mem[pred_index] &&
                          (tag_mem[pred_index] == pred_tag);
            pred_ctr_q <= ctr_mem[pred_index];
            pred_u_q   <= u_mem[pred_index];
        end
    end

    assign pred_hit   = pred_hit_q;
    assign pred_ctr   = pred_ctr_q;
    assign pred_u     = pred_u_q;
    assign flush_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_tage_tagged_bank.sv
// Bench for tage_tagged_bank: a table-level reference model is stepped on
// every rising edge and all outputs are compared on every falling edge,
// alongside hand-computed literal expectations for the key scenarios.
module tb_tage_tagged_bank;
    localparam int IW = 10;
    localparam int TW = 8;
    localparam int N  = 1 << IW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pause = 1'b0;
    logic [IW-1:0] pred_index = '0;
    logic [TW-1:0] pred_tag = '0;
    logic          pred_hit;
    logic [2:0]    pred_ctr;
    logic [1:0]    pred_u;
    logic          upd_valid = 1'b0;
    logic [IW-1:0] upd_index = '0;
    logic [TW-1:0] upd_tag = '0;
    logic          upd_alloc = 1'b0;
    logic          upd_taken = 1'b0;
    logic          upd_u_inc = 1'b0;
    logic          upd_u_dec = 1'b0;
    logic          flush_ubits_hi = 1'b0;
    logic          flush_ubits_lo = 1'b0;
    logic          flush_busy;

    tage_tagged_bank #(.INDEX_W(IW), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .pause(pause),
        .pred_index(pred_index), .pred_tag(pred_tag),
        .pred_hit(pred_hit), .pred_ctr(pred_ctr), .pred_u(pred_u),
        .upd_valid(upd_valid), .upd_index(upd_index), .upd_tag(upd_tag),
        .upd_alloc(upd_alloc), .upd_taken(upd_taken),
        .upd_u_inc(upd_u_inc), .upd_u_dec(upd_u_dec),
        .flush_ubits_hi(flush_ubits_hi), .flush_ubits_lo(flush_ubits_lo),
        .flush_busy(flush_busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: table contents plus "what is the sweeper doing"
    bit mvalid [N];
    int mtag [N];
    int mctr [N];
    int mu   [N];
    bit mknown [N];
    bit minit, mswp;
    int mpos, mclr, mpend;
    bit e_hit, e_known;
    int e_ctr, e_u;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        minit = 1; mswp = 0; mpos = 0; mclr = 0; mpend = 0;
        e_hit = 0; e_ctr = 0; e_u = 0; e_known = 1;
        // entry 0 may be scrubbed by clock edges while reset is held
        mknown[0] = 0;
    endtask

    task automatic model_step();
        int i, req;
        if (rst) return;
        if (!pause) begin
            i = int'(pred_index);
            e_hit   = !minit && mvalid[i] && (mtag[i] == int'(pred_tag));
            e_ctr   = mctr[i];
            e_u     = mu[i];
            e_known = mknown[i];
        end
        req = (flush_ubits_hi ? 2 : 0) + (flush_ubits_lo ? 1 : 0);
        if (minit) begin
            mvalid[mpos] = 0; mtag[mpos] = 0; mctr[mpos] = 0; mu[mpos] = 0;
            mknown[mpos] = 1;
        end else begin
            if (upd_valid) begin
                i = int'(upd_index);
                if (upd_alloc) begin
                    mvalid[i] = 1; mtag[i] = int'(upd_tag);
                    mctr[i] = upd_taken ? 4 : 3; mu[i] = 0;
                end else begin
                    if (upd_taken) mctr[i] = (mctr[i] < 7) ? mctr[i] + 1 : 7;
                    else           mctr[i] = (mctr[i] > 0) ? mctr[i] - 1 : 0;
                    if (upd_u_inc && !upd_u_dec)      mu[i] = (mu[i] < 3) ? mu[i] + 1 : 3;
                    else if (upd_u_dec && !upd_u_inc) mu[i] = (mu[i] > 0) ? mu[i] - 1 : 0;
                end
            end
            if (mswp) mu[mpos] = mu[mpos] & ~mclr & 3;
        end
        if (minit) begin
            if (mpos == N - 1) begin minit = 0; mpos = 0; end
            else mpos++;
        end else if (mswp) begin
            if (mpos == N - 1) begin
                mpos = 0;
                if (mpend != 0) mclr = mpend;
                else mswp = 0;
                mpend = req;
            end else begin
                mpos++;
                mpend = mpend | req;
            end
        end else if ((req | mpend) != 0) begin
            mswp = 1; mclr = req | mpend; mpend = 0; mpos = 0;
        end
    endtask

    task automatic compare();
        chk("busy", 32'(flush_busy), 32'(minit || mswp));
        chk("hit", 32'(pred_hit), 32'(e_hit));
        if (e_known) begin
            chk("ctr", 32'(pred_ctr), 32'(e_ctr));
            chk("u", 32'(pred_u), 32'(e_u));
        end
    endtask

    // One clock: model steps at the edge, outputs checked on the falling edge
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
        #1;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        do begin cyc(); n++; end while (flush_busy && n < 5000);
    endtask

    task automatic look(input int idx, input int tag);
        pred_index = IW'(idx); pred_tag = TW'(tag);
        cyc();
    endtask

    task automatic upd(input int idx, input int tag, input bit alloc, input bit taken,
                       input bit inc, input bit dec);
        upd_valid = 1; upd_index = IW'(idx); upd_tag = TW'(tag);
        upd_alloc = alloc; upd_taken = taken; upd_u_inc = inc; upd_u_dec = dec;
        cyc();
        upd_valid = 0; upd_alloc = 0; upd_u_inc = 0; upd_u_dec = 0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < N; i++) begin
            mvalid[i] = 0; mtag[i] = 0; mctr[i] = 0; mu[i] = 0; mknown[i] = 0;
        end
        model_reset();
        repeat (3) cyc();
        chk("rst_hit", 32'(pred_hit), 0);
        chk("rst_ctr", 32'(pred_ctr), 0);
        chk("rst_u", 32'(pred_u), 0);
        chk("rst_busy", 32'(flush_busy), 1);

        // Init pass with lookups held
        rst = 0;
        wait_idle(n);
        chk("init_cycles", n, 1024);

        // Every index misses after init
        for (int i = 0; i < N; i++) look(i, int'($urandom_range(255, 0)));
        chk("miss_last", 32'(pred_hit), 0);

        // Allocate then look up
        upd(5, 'h3C, 1, 1, 0, 0);
        look(5, 'h3C);
        chk("alloc_hit", 32'(pred_hit), 1);
        chk("alloc_ctr", 32'(pred_ctr), 4);
        chk("alloc_u", 32'(pred_u), 0);
        look(5, 'h3D);
        chk("tag_miss", 32'(pred_hit), 0);
        upd(9, 'hAA, 1, 0, 1, 0);
        look(9, 'hAA);
        chk("alloc_nt_ctr", 32'(pred_ctr), 3);
        chk("alloc_nt_u", 32'(pred_u), 0);

        // Pause holds the last result
        look(5, 'h3C);
        pause = 1;
        look(9, 'h00);
        look(100, 'h01);
        chk("pause_hit", 32'(pred_hit), 1);
        chk("pause_ctr", 32'(pred_ctr), 4);
        pause = 0;

        // Training saturation
        repeat (5) upd(5, 'h00, 0, 1, 1, 0);
        look(5, 'h3C);
        chk("train_ctr_sat", 32'(pred_ctr), 7);
        chk("train_u_sat", 32'(pred_u), 3);
        chk("train_keeps_tag", 32'(pred_hit), 1);
        upd(5, 'h00, 0, 1, 1, 1);
        repeat (8) upd(5, 'h00, 0, 0, 0, 0);
        look(5, 'h3C);
        chk("train_ctr_zero", 32'(pred_ctr), 0);
        chk("u_both_hold", 32'(pred_u), 3);

        // Single hi flush
        flush_ubits_hi = 1; cyc(); flush_ubits_hi = 0;
        wait_idle(n);
        chk("flush_cycles", n, 1024);
        look(5, 'h3C);
        chk("flush_hi_u", 32'(pred_u), 1);

        // hi flush, lo requested mid-sweep -> chained second pass
        upd(5, 'h00, 0, 1, 1, 0);
        upd(5, 'h00, 0, 1, 1, 0);
        flush_ubits_hi = 1; cyc(); flush_ubits_hi = 0;
        n = 0;
        do begin
            flush_ubits_lo = (n == 300);
            cyc(); n++;
        end while (flush_busy && n < 5000);
        flush_ubits_lo = 0;
        chk("flush2_cycles", n, 2048);
        look(5, 'h3C);
        chk("flush2_u", 32'(pred_u), 0);

        // Lookup + u_inc on the entry being swept with both planes clearing
        upd(7, 'h11, 1, 1, 0, 0);
        upd(7, 'h00, 0, 1, 1, 0);
        upd(7, 'h00, 0, 1, 1, 0);
        flush_ubits_hi = 1; flush_ubits_lo = 1; cyc();
        flush_ubits_hi = 0; flush_ubits_lo = 0;
        repeat (7) cyc();
        pred_index = 7; pred_tag = 'h11;
        upd(7, 'h00, 0, 1, 1, 0);
        chk("collide_old_u", 32'(pred_u), 2);
        chk("collide_hit", 32'(pred_hit), 1);
        wait_idle(n);
        look(7, 'h11);
        chk("collide_new_u", 32'(pred_u), 0);

        // Asynchronous reset in the middle of a flush
        look(5, 'h3C);
        flush_ubits_hi = 1; cyc(); flush_ubits_hi = 0;
        repeat (100) cyc();
        #2;
        rst = 1;
        model_reset();
        #1;
        chk("arst_hit", 32'(pred_hit), 0);
        chk("arst_ctr", 32'(pred_ctr), 0);
        chk("arst_u", 32'(pred_u), 0);
        chk("arst_busy", 32'(flush_busy), 1);
        pred_index = 3;
        repeat (3) cyc();
        rst = 0;
        wait_idle(n);
        chk("reinit_cycles", n, 1024);
        look(5, 'h3C);
        chk("reinit_miss", 32'(pred_hit), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
